// File: rtl/clk_display_ctrl.sv
// clk_display_ctrl: clock and display control for the producer/consumer FIFO demo.
//   - Latches a 3-bit clk_2 program on each rising edge of the update button.
//   - Divides the system clock into a fixed producer clock (clk_1) and a
//     programmable consumer clock (clk_2), both driven straight from flops.
//   - Scans an 8-digit active-low 7-segment display showing consumed data,
//     the active producer module and the applied program.
// Build option: define CLK_DISPLAY_CTRL_INPUT_SYNC_EN to pass the raw update
// button through a 2-flop synchronizer ahead of the edge detector.
module clk_display_ctrl #(
  parameter int unsigned CLK1_HALF      = 50_000_000,
  parameter int unsigned CLK2_BASE_HALF = 25_000_000,
  parameter int unsigned REFRESH_DIV    = 100_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        update,
  input  logic [2:0]  prog_in,
  input  logic [15:0] data_2,
  input  logic [1:0]  module_sel,
  output logic        clk_1,
  output logic        clk_2,
  output logic [2:0]  prog_out,
  output logic [7:0]  an,
  output logic [7:0]  dec_ddp
);

  localparam int C1_W = (CLK1_HALF > 1) ? $clog2(CLK1_HALF) : 1;
  localparam int RF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  // The slowest program (7) stretches the base half-period by 128.
  localparam longint C2_MAX = longint'(CLK2_BASE_HALF) * 128;
  localparam int C2_W = $clog2(C2_MAX + 1);

  localparam logic [C1_W-1:0] C1_LAST = C1_W'(CLK1_HALF - 1);
  localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_DIV - 1);
  localparam logic [C2_W-1:0] C2_BASE = C2_W'(CLK2_BASE_HALF);

  logic            w_upd;
  logic            r_prev;
  logic            w_pulse;
  logic            w_prog_chg;
  logic [2:0]      r_prog;
  logic [C1_W-1:0] r_cnt1;
  logic            r_clk_1;
  logic [C2_W-1:0] r_cnt2;
  logic [C2_W-1:0] w_h2_last;
  logic            r_clk_2;
  logic [RF_W-1:0] r_ref;
  logic [2:0]      r_idx;
  logic [3:0]      w_nib;
  logic            w_blank;
  logic [7:0]      w_seg;

`ifdef CLK_DISPLAY_CTRL_INPUT_SYNC_EN
  logic [1:0] r_sync;

  // Two-flop synchronizer: the button is asynchronous to clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], update};
  end

  assign w_upd = r_sync[1];
`else
  assign w_upd = update;
`endif

  // Previous button level for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= w_upd;
  end

  assign w_pulse    = w_upd & ~r_prev;
  // Reloading the same program is not a change, so clk_2 keeps its phase.
  assign w_prog_chg = w_pulse && (prog_in != r_prog);

  // Program latch: loads only on a button edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        r_prog <= 3'd0;
    else if (w_pulse) r_prog <= prog_in;
  end

  // Fixed producer clock divider.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt1  <= '0;
      r_clk_1 <= 1'b0;
    end else if (r_cnt1 == C1_LAST) begin
      r_cnt1  <= '0;
      r_clk_1 <= ~r_clk_1;
    end else begin
      r_cnt1  <= r_cnt1 + 1'b1;
    end
  end

  assign w_h2_last = (C2_BASE << r_prog) - C2_W'(1);

  // Programmable consumer clock divider; a new program restarts the half
  // period from zero but leaves the clk_2 level untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt2  <= '0;
      r_clk_2 <= 1'b0;
    end else if (w_prog_chg) begin
      r_cnt2  <= '0;
    end else if (r_cnt2 == w_h2_last) begin
      r_cnt2  <= '0;
      r_clk_2 <= ~r_clk_2;
    end else begin
      r_cnt2  <= r_cnt2 + 1'b1;
    end
  end

  // Display refresh timer and digit index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ref <= '0;
      r_idx <= 3'd0;
    end else if (r_ref == RF_LAST) begin
      r_ref <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_ref <= r_ref + 1'b1;
    end
  end

  // Select the nibble (or blank) for the active digit.
  always_comb begin
    w_nib   = 4'h0;
    w_blank = 1'b0;
    case (r_idx)
      3'd0: w_nib = data_2[3:0];
      3'd1: w_nib = data_2[7:4];
      3'd2: w_nib = data_2[11:8];
      3'd3: w_nib = data_2[15:12];
      3'd4: w_blank = 1'b1;
      3'd5: begin
        if (module_sel == 2'd3) w_blank = 1'b1;
        else                    w_nib   = {2'b00, module_sel};
      end
      3'd6: w_blank = 1'b1;
      3'd7: w_nib = {1'b0, r_prog};
      default: w_blank = 1'b1;
    endcase
  end

  // Hex to active-low {a,b,c,d,e,f,g,dp}; dp is always off.
  always_comb begin
    w_seg = 8'hFF;
    case (w_nib)
      4'h0: w_seg = 8'b0000_0011;
      4'h1: w_seg = 8'b1001_1111;
      4'h2: w_seg = 8'b0010_0101;
      4'h3: w_seg = 8'b0000_1101;
      4'h4: w_seg = 8'b1001_1001;
      4'h5: w_seg = 8'b0100_1001;
      4'h6: w_seg = 8'b0100_0001;
      4'h7: w_seg = 8'b0001_1111;
      4'h8: w_seg = 8'b0000_0001;
      4'h9: w_seg = 8'b0000_1001;
      4'hA: w_seg = 8'b0001_0001;
      4'hB: w_seg = 8'b1100_0001;
      4'hC: w_seg = 8'b0110_0011;
      4'hD: w_seg = 8'b1000_0101;
      4'hE: w_seg = 8'b0110_0001;
      4'hF: w_seg = 8'b0111_0001;
      default: w_seg = 8'hFF;
    endcase
    if (w_blank) w_seg = 8'hFF;
  end

  assign clk_1    = r_clk_1;
  assign clk_2    = r_clk_2;
  assign prog_out = r_prog;
  assign an       = ~(8'b0000_0001 << r_idx);
  assign dec_ddp  = w_seg;

endmodule

// File: tb/tb_clk_display_ctrl.sv
// Scoreboard bench for clk_display_ctrl with small divider/refresh values.
// Stimulus pushes expected events; monitors pop and compare when the DUT
// toggles a clock, changes prog_out or advances the display digit.
module tb_clk_display_ctrl;

  localparam int C1H = 4;
  localparam int C2B = 2;
  localparam int RD  = 2;
`ifdef CLK_DISPLAY_CTRL_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        update = 1'b0;
  logic [2:0]  prog_in = 3'd0;
  logic [15:0] data_2 = 16'hF721;
  logic [1:0]  module_sel = 2'd1;
  logic        clk_1, clk_2;
  logic [2:0]  prog_out;
  logic [7:0]  an, dec_ddp;

  typedef struct {int cyc; logic [2:0] val;} prog_t;
  typedef struct {int cyc; logic [7:0] an; logic [7:0] seg;} disp_t;
  typedef struct {logic c1; logic c2; logic [2:0] prog; logic [7:0] an; logic [7:0] seg;} snap_t;

  int    q_c1[$];
  int    q_c2[$];
  prog_t q_prog[$];
  disp_t q_disp[$];
  snap_t q_snap[$];

  bit on_c1 = 0, on_c2 = 0, on_prog = 0, on_disp = 0;
  event ev_snap;

  int cyc;
  int total = 0;
  int bad   = 0;

  logic       p_c1 = 1'b0, p_c2 = 1'b0;
  logic [2:0] p_prog = 3'd0;
  logic [7:0] p_an = 8'hFE;

  // Expected segments per digit index for the two display windows.
  logic [7:0] w1_seg [8] = '{8'h9F, 8'h25, 8'h1F, 8'h71, 8'hFF, 8'h9F, 8'hFF, 8'h25};
  logic [7:0] w2_seg [8] = '{8'h03, 8'h85, 8'h99, 8'hC1, 8'hFF, 8'hFF, 8'hFF, 8'h25};

  clk_display_ctrl #(
    .CLK1_HALF(C1H), .CLK2_BASE_HALF(C2B), .REFRESH_DIV(RD)
  ) dut (
    .clock(clock), .reset(reset), .update(update), .prog_in(prog_in),
    .data_2(data_2), .module_sel(module_sel), .clk_1(clk_1), .clk_2(clk_2),
    .prog_out(prog_out), .an(an), .dec_ddp(dec_ddp)
  );

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm, input int act);
    total++;
    bad++;
    $display("FAIL %s: unexpected change to 0x%0h at cyc %0d", nm, act, cyc);
  endtask

  task automatic wait_cyc(input int t);
    for (int i = 0; i < 400 && cyc != t; i++) @(negedge clock);
    chk("wait_cyc_reached", cyc, t);
  endtask

  task automatic push_window(input int first, input int last, input int w);
    for (int c = first; c <= last; c += 2) begin
      int idx;
      idx = (c / 2) % 8;
      q_disp.push_back('{c, ~(8'b0000_0001 << idx), (w == 1) ? w1_seg[idx] : w2_seg[idx]});
    end
  endtask

  // Event monitor: compares each observed DUT output change against the queue head.
  always @(negedge clock) begin
    if (on_c1 && clk_1 !== p_c1) begin
      if (q_c1.size() == 0) unexpected("clk_1_toggle", int'(clk_1));
      else begin chk("clk_1_toggle_cyc", cyc, q_c1[0]); void'(q_c1.pop_front()); end
    end
    if (on_c2 && clk_2 !== p_c2) begin
      if (q_c2.size() == 0) unexpected("clk_2_toggle", int'(clk_2));
      else begin chk("clk_2_toggle_cyc", cyc, q_c2[0]); void'(q_c2.pop_front()); end
    end
    if (on_prog && prog_out !== p_prog) begin
      if (q_prog.size() == 0) unexpected("prog_out", int'(prog_out));
      else begin
        chk("prog_out_cyc", cyc, q_prog[0].cyc);
        chk("prog_out_val", int'(prog_out), int'(q_prog[0].val));
        void'(q_prog.pop_front());
      end
    end
    if (on_disp && an !== p_an) begin
      if (q_disp.size() == 0) unexpected("an_step", int'(an));
      else begin
        chk("digit_cyc", cyc, q_disp[0].cyc);
        chk("digit_an", int'(an), int'(q_disp[0].an));
        chk("digit_seg", int'(dec_ddp), int'(q_disp[0].seg));
        void'(q_disp.pop_front());
      end
    end
    p_c1   <= clk_1;
    p_c2   <= clk_2;
    p_prog <= prog_out;
    p_an   <= an;
  end

  // Snapshot monitor: full output state at stimulus-chosen instants.
  always @(ev_snap) begin
    while (q_snap.size() > 0) begin
      chk("snap_clk_1", int'(clk_1), int'(q_snap[0].c1));
      chk("snap_clk_2", int'(clk_2), int'(q_snap[0].c2));
      chk("snap_prog", int'(prog_out), int'(q_snap[0].prog));
      chk("snap_an", int'(an), int'(q_snap[0].an));
      chk("snap_seg", int'(dec_ddp), int'(q_snap[0].seg));
      void'(q_snap.pop_front());
    end
  end

  initial begin
    int p_cyc, q_cyc;
    p_cyc = 11 + LAT;
    q_cyc = 41 + LAT;

    repeat (3) @(negedge clock);
    q_snap.push_back('{1'b0, 1'b0, 3'd0, 8'hFE, 8'h9F});
    #1 -> ev_snap;

    for (int c = 4; c <= 100; c += 4) q_c1.push_back(c);
    for (int c = 2; c <= 10; c += 2) q_c2.push_back(c);
    q_c2.push_back(p_cyc + 16);
    for (int c = q_cyc + 8; c <= 100; c += 8) q_c2.push_back(c);
    q_prog.push_back('{p_cyc, 3'd3});
    q_prog.push_back('{q_cyc, 3'd2});
    on_c1 = 1; on_c2 = 1; on_prog = 1;

    @(negedge clock);
    reset = 1'b0;

    wait_cyc(10);
    prog_in = 3'd3;
    update  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (cyc >= p_cyc) prog_in = k[0] ? 3'd5 : 3'd6;
    end
    update  = 1'b0;
    prog_in = 3'd4;

    wait_cyc(40);
    prog_in = 3'd2;
    update  = 1'b1;
    repeat (4) @(negedge clock);
    update  = 1'b0;

    wait_cyc(61);
    push_window(62, 76, 1);
    on_disp = 1;
    wait_cyc(77);
    on_disp    = 0;
    data_2     = 16'hB4D0;
    module_sel = 2'd3;
    wait_cyc(79);
    push_window(80, 94, 2);
    on_disp = 1;
    wait_cyc(95);
    on_disp = 0;

    wait_cyc(101);
    on_c1 = 0; on_c2 = 0; on_prog = 0;
    chk("clk_1_queue_drained", q_c1.size(), 0);
    chk("clk_2_queue_drained", q_c2.size(), 0);
    chk("prog_queue_drained", q_prog.size(), 0);
    chk("disp_queue_drained", q_disp.size(), 0);

    #2 reset = 1'b1;
    q_snap.push_back('{1'b0, 1'b0, 3'd0, 8'hFE, 8'h03});
    #1 -> ev_snap;

    repeat (2) @(negedge clock);
    q_c1.push_back(4); q_c1.push_back(8); q_c1.push_back(12);
    on_c1 = 1;
    reset = 1'b0;
    wait_cyc(13);
    on_c1 = 0;
    chk("clk_1_restart_drained", q_c1.size(), 0);
    q_snap.push_back('{1'b1, 1'b0, 3'd0, 8'hBF, 8'hFF});
    #1 -> ev_snap;
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
